// File: rtl/operand_issue.sv
// operand_issue: 4 x DW register file with a pending scoreboard, feeding a one-deep ALU issue register.
// Build option OPERAND_ISSUE_FORWARD_EN: forward same-cycle writeback data to sources instead of stalling.
module operand_issue_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    input  logic          set_pend,
    output logic [DW-1:0] data,
    output logic          pend
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            pend <= 1'b0;
        end else begin
            if (we) data <= wdata;
            // a fresh claim on this register outlives a writeback landing in the same cycle
            if (set_pend)  pend <= 1'b1;
            else if (we)   pend <= 1'b0;
        end
    end
endmodule

module operand_issue #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    instr,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] rs1,
    output logic [DW-1:0] rs2,
    output logic [2:0]    ctrl,
    output logic          flag,
    output logic [1:0]    rd,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          wb_en,
    input  logic [1:0]    wb_addr,
    input  logic [DW-1:0] wb_data
);
    localparam int NREG = 4;
    localparam int NSRC = 2;

    typedef struct packed {
        logic [2:0]    ctrl;
        logic          flag;
        logic [1:0]    rd;
        logic [DW-1:0] rs1;
        logic [DW-1:0] rs2;
    } iss_t;

    logic [NREG-1:0][DW-1:0] rf;
    logic [NREG-1:0]         pending;
    logic [NSRC-1:0][1:0]    src;
    logic [NSRC-1:0][DW-1:0] opnd;
    logic [NSRC-1:0]         blk;
    logic                    stall;
    logic                    accept;
    iss_t                    iss_q;
    iss_t                    iss_d;

    // source 0 doubles as the destination index
    assign src[0] = instr[3:2];
    assign src[1] = instr[1:0];

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        logic hit;
        assign hit = wb_en && (wb_addr == src[s]);
`ifdef OPERAND_ISSUE_FORWARD_EN
        assign blk[s]  = pending[src[s]] && !hit;
        assign opnd[s] = hit ? wb_data : rf[src[s]];
`else
        logic unused_hit;
        assign unused_hit = hit;
        assign blk[s]  = pending[src[s]];
        assign opnd[s] = rf[src[s]];
`endif
    end

    assign stall    = |blk;
    assign in_ready = (!out_valid || out_ready) && !stall;
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        operand_issue_reg #(.DW(DW)) u_reg (
            .clk      (clk),
            .rst_n    (rst_n),
            .we       (wb_en && (wb_addr == 2'(i))),
            .wdata    (wb_data),
            .set_pend (accept && (src[0] == 2'(i))),
            .data     (rf[i]),
            .pend     (pending[i])
        );
    end

    always_comb begin
        iss_d      = iss_q;
        iss_d.ctrl = instr[7:5];
        iss_d.flag = instr[4];
        iss_d.rd   = instr[3:2];
        iss_d.rs1  = opnd[0];
        iss_d.rs2  = opnd[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_q     <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            iss_q     <= iss_d;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign ctrl = iss_q.ctrl;
    assign flag = iss_q.flag;
    assign rd   = iss_q.rd;
    assign rs1  = iss_q.rs1;
    assign rs2  = iss_q.rs2;
endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: directed scenarios plus random traffic against a register-file/scoreboard model.
module tb_operand_issue;
    localparam int DW = 8;
`ifdef OPERAND_ISSUE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    instr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] rs1, rs2;
    logic [2:0]    ctrl;
    logic          flag;
    logic [1:0]    rd;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          wb_en = 1'b0;
    logic [1:0]    wb_addr = '0;
    logic [DW-1:0] wb_data = '0;

    operand_issue #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .ctrl(ctrl), .flag(flag), .rd(rd), .out_valid(out_valid),
        .out_ready(out_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    logic [7:0] m_rf [4];
    bit         m_pend [4];
    bit         m_ov;
    logic [7:0] m_rs1, m_rs2;
    logic [2:0] m_ctrl;
    bit         m_flag;
    logic [1:0] m_rd;
    bit         seen_rdy;
    logic [7:0] hold_rs1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_blocked(input logic [1:0] s);
        return m_pend[s] && !(FWD && wb_en && wb_addr == s);
    endfunction

    function automatic logic [7:0] m_operand(input logic [1:0] s);
        return (FWD && wb_en && wb_addr == s) ? wb_data : m_rf[s];
    endfunction

    function automatic bit m_ready();
        return (!m_ov || out_ready) && !m_blocked(instr[3:2]) && !m_blocked(instr[1:0]);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_rf[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_ov = 0; m_rs1 = '0; m_rs2 = '0; m_ctrl = '0; m_flag = 0; m_rd = '0;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_out_valid"}, out_valid, m_ov);
        chk({pfx, "_rs1"}, rs1, m_rs1);
        chk({pfx, "_rs2"}, rs2, m_rs2);
        chk({pfx, "_ctrl"}, ctrl, m_ctrl);
        chk({pfx, "_flag"}, flag, m_flag);
        chk({pfx, "_rd"}, rd, m_rd);
    endtask

    // inputs are already driven; settle, check ready, clock, advance model, check outputs
    task automatic cycle();
        bit acc;
        logic [7:0] a, b;
        #1;
        seen_rdy = in_ready;
        chk("in_ready", in_ready, m_ready());
        acc = in_valid && m_ready();
        a = m_operand(instr[3:2]);
        b = m_operand(instr[1:0]);
        @(posedge clk);
        if (acc) begin
            m_ov = 1; m_rs1 = a; m_rs2 = b;
            m_ctrl = instr[7:5]; m_flag = instr[4]; m_rd = instr[3:2];
        end else if (out_ready) begin
            m_ov = 0;
        end
        if (wb_en) begin
            m_rf[wb_addr] = wb_data;
            m_pend[wb_addr] = 0;
        end
        if (acc) m_pend[instr[3:2]] = 1;
        #1;
        check_outputs("cyc");
    endtask

    task automatic drive(input bit iv, input logic [7:0] ins, input bit ordy,
                         input bit we, input logic [1:0] wa, input logic [7:0] wd);
        in_valid = iv; instr = ins; out_ready = ordy;
        wb_en = we; wb_addr = wa; wb_data = wd;
        cycle();
    endtask

    task automatic flush_all();
        for (int i = 0; i < 4; i++) drive(0, 8'h00, 1, 1, 2'(i), m_rf[i]);
    endtask

    initial begin
        m_reset();
        #3;
        check_outputs("reset");
        #9 rst_n = 1'b1;

        // first accept right after reset: all-zero operands
        drive(1, 8'h64, 1, 0, 0, 0);
        chk("r032_valid", out_valid, 1);
        chk("r032_ctrl", ctrl, 3);
        chk("r032_rd", rd, 1);
        chk("r032_rs1", rs1, 8'h00);

        drive(0, 8'h00, 1, 1, 2'd1, 8'h11);
        drive(0, 8'h00, 1, 1, 2'd2, 8'h5A);
        drive(0, 8'h00, 1, 1, 2'd3, 8'h0F);
        drive(1, 8'h7B, 1, 0, 0, 0);
        chk("r033_rs1", rs1, 8'h5A);
        chk("r033_rs2", rs2, 8'h0F);
        chk("r033_flag", flag, 1);
        drive(1, 8'h68, 1, 0, 0, 0);
        chk("r033_pend2_stall", seen_rdy, 0);
        drive(0, 8'h00, 1, 1, 2'd2, 8'h22);

        // backpressure: three held cycles, then replace with no bubble
        drive(1, 8'h40, 1, 0, 0, 0);
        hold_rs1 = rs1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h25, 0, 0, 0, 0);
            chk("r034_blocked", seen_rdy, 0);
        end
        chk("r034_hold_rs1", rs1, hold_rs1);
        chk("r034_hold_rd", rd, 0);
        drive(1, 8'h25, 1, 0, 0, 0);
        chk("r034_nobubble_valid", out_valid, 1);
        chk("r034_nobubble_rd", rd, 1);
        flush_all();

        // same-cycle writeback resolving a pending source
        drive(1, 8'h04, 1, 0, 0, 0);
        drive(1, 8'h05, 1, 1, 2'd1, 8'hA5);
        if (FWD) begin
            chk("r035_fwd_accept", seen_rdy, 1);
        end else begin
            chk("r035_stall", seen_rdy, 0);
            drive(1, 8'h05, 1, 0, 0, 0);
        end
        chk("r035_rs1", rs1, 8'hA5);
        chk("r035_rs2", rs2, 8'hA5);
        flush_all();

        // pending source holds off until its writeback
        drive(1, 8'h00, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h0C, 1, 0, 0, 0);
            chk("r036_blocked", seen_rdy, 0);
        end
        drive(1, 8'h0C, 1, 1, 2'd0, 8'h33);
        if (!FWD) drive(1, 8'h0C, 1, 0, 0, 0);
        chk("r036_rs2", rs2, 8'h33);
        flush_all();

        // accept and writeback to the same rd: register written, pending stays set
        drive(1, 8'h6D, 1, 1, 2'd3, 8'h77);
        drive(1, 8'h0C, 1, 0, 0, 0);
        chk("r026_pend_set", seen_rdy, 0);
        drive(1, 8'h0C, 1, 1, 2'd3, 8'h78);
        if (!FWD) drive(1, 8'h0C, 1, 0, 0, 0);
        chk("r026_rs1", rs1, 8'h78);
        flush_all();

        // asynchronous reset while an instruction is held and pending[2] is set
        drive(1, 8'h48, 0, 0, 0, 0);
        chk("r037_pre_valid", out_valid, 1);
        instr = 8'h08; in_valid = 1; out_ready = 0;
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        chk("r037_out_valid", out_valid, 0);
        chk("r037_rs1", rs1, 0);
        chk("r037_rd", rd, 0);
        chk("r037_pend_clear", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 4, 2'($urandom), 8'($urandom));
        end
        drive(0, 8'h00, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/operand_issue.md
OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 Parameter: DW, 8, datapath width of registers, operands and writeback data; only 8 is supported.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: instr  input  8  instruction; [7:5] ctrl, [4] flag, [3:2] rd/rs1 index, [1:0] rs2 index.
REQ-005 Port: in_valid  input  1  instr is valid this cycle.
REQ-006 Port: in_ready  output  1  block accepts instr this cycle.
REQ-007 Port: rs1  output  DW  first ALU operand, registered.
REQ-008 Port: rs2  output  DW  second ALU operand, registered.
REQ-009 Port: ctrl  output  3  ALU operation select, registered copy of instr[7:5].
REQ-010 Port: flag  output  1  ALU variant select, registered copy of instr[4].
REQ-011 Port: rd  output  2  destination index, registered copy of instr[3:2].
REQ-012 Port: out_valid  output  1  rs1/rs2/ctrl/flag/rd hold an issued instruction.
REQ-013 Port: out_ready  input  1  downstream ALU/writeback consumes the issued instruction.
REQ-014 Port: wb_en  input  1  writeback strobe.
REQ-015 Port: wb_addr  input  2  writeback register index.
REQ-016 Port: wb_data  input  DW  writeback value, i.e. the ALU out.

Function
REQ-017 Block SHALL hold a 4 x DW register file and a 4-bit pending scoreboard.
REQ-018 Accept SHALL occur on a cycle with in_valid & in_ready; the accepted instruction SHALL appear on the outputs with out_valid=1 on the next cycle (latency 1).
REQ-019 in_ready SHALL equal (!out_valid | out_ready) & !stall, combinationally.
REQ-020 stall SHALL be 1 when pending[instr[3:2]] or pending[instr[1:0]] is set and that source is not resolved by the same-cycle writeback (see REQ-031).
REQ-021 Output register SHALL hold all values stable while out_valid & !out_ready.
REQ-022 Handshake out_valid & out_ready without a new accept SHALL clear out_valid the next cycle.
REQ-023 Handshake and new accept in the same cycle SHALL replace the output register with no bubble.
REQ-024 On accept, operands SHALL be sampled from the register file; pending[instr[3:2]] SHALL be set.
REQ-025 wb_en SHALL write wb_data to register wb_addr and clear pending[wb_addr], whether or not that entry was pending.
REQ-026 Accept writing rd and wb_en with wb_addr equal to that rd in the same cycle: the register SHALL be written and pending SHALL end set.
REQ-027 in_valid low or stalled: no state other than writeback SHALL change.
REQ-028 ctrl values SHALL pass through unchecked.

Reset
REQ-029 rst_n low SHALL immediately clear all registers, all pending bits, and rs1, rs2, ctrl, flag, rd and out_valid to 0, mid-operation included.
REQ-030 In-flight instructions SHALL be discarded by reset; the first accept is allowed on the first clock edge after rst_n rises.

Configuration
REQ-031 With macro OPERAND_ISSUE_FORWARD_EN defined: a source matching wb_addr while wb_en=1 SHALL NOT stall and SHALL take wb_data as its operand that cycle. Without the macro: that source SHALL stall one cycle and read the register file the next cycle.

Verification
REQ-032 After reset, with no writes: instr 0x64 (ctrl=011 flag=0 rd=1 rs2=0) accepted -> next cycle out_valid=1, rs1=0x00, rs2=0x00, ctrl=3, rd=1.
REQ-033 Write reg2=0x5A and reg3=0x0F, then issue instr 0x7B (ctrl=011 flag=1 rd=2 rs2=3) -> rs1=0x5A, rs2=0x0F, flag=1, pending[2]=1.
REQ-034 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 throughout and outputs unchanged; out_ready=1 -> next instruction issued the following cycle with no bubble.
REQ-035 Issue rd=1, then an instr reading reg1 with wb_en=1, wb_addr=1, wb_data=0xA5 in the same cycle -> with macro: accepted and rs1=0xA5; without: one stall cycle, then rs1=0xA5.
REQ-036 Issue rd=0 (pending[0]=1) with no writeback, then an instr reading reg0 -> in_ready=0 until wb_addr=0 is written.
REQ-037 Drop rst_n while out_valid=1 and pending[2]=1 -> out_valid=0 and pending=0 immediately, with no clock edge.
